// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave generator with Bresenham-dithered period lengths
module freq_gen #(
  parameter int CNT_W   = 32,
  parameter int MAX_DIV = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] period_sum,
  input  logic [7:0]       divisor,
  output logic             cfg_err,
  output logic             freq_out,
  output logic             period_done,
  output logic             group_done,
  output logic [31:0]      period_count
);
  localparam int DW = $clog2(MAX_DIV + 1);
  localparam int GW = MAX_DIV + 1;
  localparam int LW = CNT_W + 1;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t             state, st_n;
  logic               active, pend_valid;
  logic [CNT_W-1:0]   base, cnt, cnt_n, lo_len, pend_sum, eb;
  logic [MAX_DIV-1:0] rem, acc, er, ea;
  logic [DW-1:0]      d, pend_div, ed;
  logic [GW-1:0]      gidx, dm, emask, asum;
  logic [LW-1:0]      len, hi, lo;
  logic               bad, take, bnd, app, start;
  assign cfg_ready = !pend_valid;
  always_comb begin
    bad   = divisor > 8'(MAX_DIV) || (period_sum >> divisor) < CNT_W'(2);
    take  = cfg_valid && cfg_ready;
    bnd   = state == LOW && cnt == '0;
    app   = pend_valid && (state == IDLE || bnd);
    ed    = app ? pend_div : d;
    emask = (GW'(1) << ed) - GW'(1);
    dm    = (GW'(1) << d) - GW'(1);
    // a freshly applied config takes effect for the period that starts in this same cycle
    eb    = app ? pend_sum >> pend_div : base;
    er    = app ? pend_sum[MAX_DIV-1:0] & emask[MAX_DIV-1:0] : rem;
    ea    = app ? '0 : acc;
    asum  = GW'(ea) + GW'(er);
    len   = LW'(eb) + LW'(asum > emask);
    hi    = (len + LW'(1)) >> 1;
    lo    = len >> 1;
    start = enable && (active || app) && (state == IDLE || bnd);
    st_n  = start ? HIGH : (state == HIGH && cnt == '0) ? LOW : bnd ? IDLE : state;
    cnt_n = start ? CNT_W'(hi - LW'(1)) :
            (state == HIGH && cnt == '0) ? lo_len - CNT_W'(1) :
            (state == IDLE || bnd) ? '0 : cnt - CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lo_len       <= '0;
      active       <= 1'b0;
      base         <= '0;
      rem          <= '0;
      d            <= '0;
      acc          <= '0;
      gidx         <= '0;
      pend_valid   <= 1'b0;
      pend_sum     <= '0;
      pend_div     <= '0;
      freq_out     <= 1'b0;
      period_done  <= 1'b0;
      group_done   <= 1'b0;
      cfg_err      <= 1'b0;
      period_count <= '0;
    end else begin
      state        <= st_n;
      cnt          <= cnt_n;
      freq_out     <= st_n == HIGH;
      period_done  <= st_n == LOW && cnt_n == '0;
      group_done   <= st_n == LOW && cnt_n == '0 && gidx == dm;
      cfg_err      <= take && bad;
      period_count <= period_count + 32'(bnd);
      if (take && !bad) begin
        pend_valid <= 1'b1;
        pend_sum   <= period_sum;
        pend_div   <= divisor[DW-1:0];
      end else if (app) pend_valid <= 1'b0;
      if (app) begin
        active <= 1'b1;
        base   <= eb;
        rem    <= er;
        d      <= ed;
      end
      if (start) begin
        acc    <= asum[MAX_DIV-1:0] & emask[MAX_DIV-1:0];
        lo_len <= CNT_W'(lo);
      end else if (app) acc <= '0;
      if (app) gidx <= '0;
      else if (bnd) gidx <= gidx == dm ? '0 : gidx + GW'(1);
    end
  end
endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable square-wave generator; transmit-side counterpart of the frequency detector.
- Config gives a total clock count spread over 2^divisor periods, using the same sum/divisor scaling the detector reports.
- Fractional periods are produced by Bresenham dithering, so the average period equals period_sum / 2^divisor exactly.
- Drives test and stimulus signals; output is directly measurable by the detector in loopback.

Parameters:
- CNT_W, 32, width of period_sum and the internal counters.
- MAX_DIV, 16, largest legal divisor; larger values are rejected.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request; sampled only in IDLE and at period boundaries
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config buffer empty
- period_sum  in  CNT_W  total clocks over 2^divisor periods
- divisor  in  8  log2 of the dithering group length
- cfg_err  out  1  one-cycle pulse: offered config rejected
- freq_out  out  1  generated square wave, registered
- period_done  out  1  one-cycle pulse on the last cycle of each period
- group_done  out  1  one-cycle pulse on the last cycle of each 2^divisor-period group
- period_count  out  32  completed periods, wraps at 2^32

Behaviour:
- Reset values:
  - freq_out=0, period_done=0, group_done=0, cfg_err=0, period_count=0, cfg_ready=1.
  - state=IDLE; no active config; pending buffer empty; acc=0.
  - Reset mid-operation: freq_out is 0 the cycle after reset is sampled; any pending config is discarded.
- Config handshake:
  - Transfer occurs on cfg_valid && cfg_ready.
  - Reject when divisor > MAX_DIV or (period_sum >> divisor) < 2.
  - On reject: cfg_err pulses the next cycle, nothing is stored, cfg_ready stays 1.
  - Accepted config goes to a one-entry pending buffer; cfg_ready=0 until it is applied.
- Config application:
  - In IDLE: applied the cycle after acceptance.
  - Running: applied at the next period boundary, after the final LOW cycle.
  - On apply: base = sum >> d; rem = sum mod 2^d; acc=0; group index=0.
  - A never-configured generator stays in IDLE regardless of enable.
- Period length, per period:
  - L = base + ((acc + rem) >= 2^d ? 1 : 0).
  - Then acc <= (acc + rem) mod 2^d.
  - With d=0, rem=0 and L=base.
- Waveform:
  - HIGH for ceil(L/2) cycles, then LOW for floor(L/2) cycles.
  - L >= 2 guarantees at least one cycle in each phase.
- States:
  - IDLE: freq_out=0.
    - If enable && config active, go to HIGH.
    - freq_out=1 starts the cycle after enable is sampled high.
  - HIGH: count down ceil(L/2), then go to LOW.
  - LOW: count down floor(L/2). On its last cycle:
    - period_done=1; period_count increments.
    - group_done=1 if the group index equals 2^d-1; index wraps to 0 and acc is 0 there by construction.
    - Next: pending config applied if present (restarts the group), then HIGH if enable, else IDLE.
- enable deassertion mid-period: the current period completes, then the block goes to IDLE. No truncated pulses.
- Simultaneous events at a period boundary:
  - A pending apply and a new cfg_valid on the same cycle: apply first; cfg_ready reasserts the following cycle.
  - A new offer is never accepted in the apply cycle.
- Arithmetic:
  - Phase counters are CNT_W bits.
  - acc and rem are MAX_DIV bits, masked to d bits.
  - The group index is MAX_DIV+1 bits.

Test Plan:
- period_sum=10, divisor=0, enable=1 → freq_out repeats 5 high / 5 low; period_done every 10 cycles; first high the cycle after enable.
- period_sum=7, divisor=0 → 4 high / 3 low, repeating; period_count increments once per 7 cycles.
- period_sum=21, divisor=2 → period lengths 5,5,5,6 (high/low 3/2,3/2,3/2,3/3); group_done on the 21st cycle; pattern repeats.
- period_sum=3, divisor=1 → cfg_err pulse, cfg_ready stays 1, freq_out stays 0. Same for divisor=17.
- While running period_sum=10/d=0, offer period_sum=4 two cycles into a period → cfg_ready drops; the current 10-cycle period completes; the next period is 2 high / 2 low; cfg_ready then returns to 1.
- Assert reset during HIGH → freq_out=0 and period_count=0 the next cycle; block stays IDLE until a new config is accepted.
